// File: rtl/aud_player_pkg.sv
// Shared audio package for the codec datapath.
// Holds the common PCM word width used by both the DAC-side player and the
// ADC-side recorder, plus the player's state encoding.
package aud_player_pkg;

  // PCM sample width exchanged with the codec, in bits.
  localparam int AUD_WORD_W = 16;

  // Player sequencing:
  //   ST_IDLE  - nothing in flight, output held low
  //   ST_DELAY - I2S one-bit delay slot right after an LR edge
  //   ST_SEND  - shifting the latched word out MSB first
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEND  = 2'd2
  } player_state_t;

endpackage : aud_player_pkg

// File: rtl/aud_player.sv
// aud_player - I2S serial transmitter for the codec DAC path.
// Converts parallel left/right PCM samples into the DACDAT serial stream,
// timed entirely by the codec's bit clock and DAC LR clock.
//
// Ports:
//   i_bclk       - codec bit clock, the only clock (rising edge)
//   i_rst_n      - asynchronous reset, active HIGH despite the suffix
//   i_daclrck    - DAC LR clock: 0 = left half-frame, 1 = right half-frame
//   i_en         - playback enable, only looked at on LR-clock edges
//   i_dac_l      - left sample, two's complement
//   i_dac_r      - right sample, two's complement
//   o_aud_dacdat - registered serial data to the codec
module aud_player
  import aud_player_pkg::*;
#(
  parameter int WORD_W = AUD_WORD_W
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_dac_l,
  input  logic [WORD_W-1:0] i_dac_r,
  output logic              o_aud_dacdat
);

  // Counter must reach WORD_W-1; one spare bit keeps the 0..WORD_W range.
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  player_state_t     state_q, state_d;
  logic              lrc_q, lrc_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dat_q, dat_d;
  logic              lr_edge;

  assign o_aud_dacdat = dat_q;

  // State register. Reset forces the output low immediately, even mid-word.
  always_ff @(posedge i_bclk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= ST_IDLE;
      lrc_q   <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      dat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lrc_q   <= lrc_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic. An LR edge overrides whatever is in flight: the old
  // word is dropped and the edge is treated exactly as if we were idle.
  // The word is shifted left so the bit to send is always shift_q[MSB],
  // which is why later changes on i_dac_l/i_dac_r cannot disturb it.
  always_comb begin
    state_d = state_q;
    lrc_d   = i_daclrck;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dat_d   = 1'b0;
    lr_edge = (i_daclrck != lrc_q);

    if (lr_edge) begin
      cnt_d = '0;
      if (i_en) begin
        shift_d = i_daclrck ? i_dac_r : i_dac_l;
        state_d = ST_DELAY;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_DELAY: begin
          dat_d   = shift_q[WORD_W-1];
          shift_d = {shift_q[WORD_W-2:0], 1'b0};
          cnt_d   = '0;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          // cnt counts bits already sent after the MSB; once the LSB has
          // been on the wire for a full cycle we drop back to idle.
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end else begin
            dat_d   = shift_q[WORD_W-1];
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule : aud_player

// File: tb/tb_aud_player.sv
// tb_aud_player - self-checking bench for aud_player.
// Drives directed and random half-frames and compares DACDAT every cycle
// against a timeline model: after an enabled LR edge at E0 the wire carries
// 0, then word bits 15..0 on E1..E16, then 0 until the next edge.
module tb_aud_player;

  logic        i_bclk;
  logic        i_rst_n;
  logic        i_daclrck;
  logic        i_en;
  logic [15:0] i_dac_l;
  logic [15:0] i_dac_r;
  logic        o_aud_dacdat;

  int n_checks;
  int n_fails;
  int cyc;
  string cur_tag;

  // Reference model state: the word on the wire and how many cycles since
  // the edge that started it.
  logic        m_prev_lr;
  bit          m_active;
  int          m_age;
  logic [15:0] m_word;
  logic        exp_dat;

  aud_player #(.WORD_W(16)) dut (
    .i_bclk       (i_bclk),
    .i_rst_n      (i_rst_n),
    .i_daclrck    (i_daclrck),
    .i_en         (i_en),
    .i_dac_l      (i_dac_l),
    .i_dac_r      (i_dac_r),
    .o_aud_dacdat (o_aud_dacdat)
  );

  initial i_bclk = 1'b0;
  always #5 i_bclk = ~i_bclk;

  // Advance the model by one rising bclk using the inputs present there.
  task automatic model_edge();
    if (i_rst_n) begin
      m_prev_lr = 1'b0;
      m_active  = 1'b0;
      m_age     = 0;
    end else begin
      if (i_daclrck !== m_prev_lr) begin
        if (i_en) begin
          m_word   = i_daclrck ? i_dac_r : i_dac_l;
          m_active = 1'b1;
          m_age    = 0;
        end else begin
          m_active = 1'b0;
        end
      end else if (m_active) begin
        m_age++;
        if (m_age > 16) m_active = 1'b0;
      end
      m_prev_lr = i_daclrck;
    end
    if (m_active && m_age >= 1 && m_age <= 16) exp_dat = m_word[16 - m_age];
    else exp_dat = 1'b0;
  endtask

  task automatic check_output();
    n_checks++;
    assert (o_aud_dacdat === exp_dat)
    else begin
      n_fails++;
      $error("[TB] FAIL %s cyc=%0d dacdat=%b expected=%b", cur_tag, cyc, o_aud_dacdat, exp_dat);
    end
  endtask

  // One bclk period: inputs change on the falling edge, output is checked
  // 1ns after the rising edge.
  task automatic run_cycle(input logic lr, input logic en, input logic [15:0] l,
                           input logic [15:0] r);
    @(negedge i_bclk);
    i_daclrck = lr;
    i_en      = en;
    i_dac_l   = l;
    i_dac_r   = r;
    @(posedge i_bclk);
    model_edge();
    cyc++;
    #1;
    check_output();
  endtask

  task automatic half_frame(input logic lr, input int len, input logic en,
                            input logic [15:0] l, input logic [15:0] r);
    for (int k = 0; k < len; k++) run_cycle(lr, en, l, r);
  endtask

  logic [15:0] sweep_l [4];
  logic [15:0] sweep_r [4];

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    cyc       = 0;
    m_prev_lr = 1'b0;
    m_active  = 1'b0;
    m_age     = 0;
    m_word    = '0;
    exp_dat   = 1'b0;
    i_rst_n   = 1'b1;
    i_daclrck = 1'b0;
    i_en      = 1'b1;
    i_dac_l   = 16'hFFFF;
    i_dac_r   = 16'hFFFF;

    sweep_l[0] = 16'hFFFF; sweep_r[0] = 16'h0000;
    sweep_l[1] = 16'hEDB7; sweep_r[1] = 16'h1248;
    sweep_l[2] = 16'hC936; sweep_r[2] = 16'h36C9;
    sweep_l[3] = 16'h8124; sweep_r[3] = 16'h7EDB;

    // Reset held while LR toggles: nothing may leave the pin.
    cur_tag = "reset";
    run_cycle(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    run_cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    run_cycle(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    run_cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    @(negedge i_bclk);
    i_rst_n = 1'b0;

    cur_tag = "disabled";
    for (int f = 0; f < 2; f++) begin
      half_frame(1'b1, 20, 1'b0, 16'hFFFF, 16'hFFFF);
      half_frame(1'b0, 20, 1'b0, 16'hFFFF, 16'hFFFF);
    end

    cur_tag = "left";
    half_frame(1'b1, 20, 1'b1, 16'h0000, 16'h0000);
    half_frame(1'b0, 20, 1'b1, 16'hEDB7, 16'h0000);
    cur_tag = "right";
    half_frame(1'b1, 20, 1'b1, 16'h0000, 16'h1248);

    cur_tag = "sweep";
    for (int f = 0; f < 4; f++) begin
      half_frame(1'b0, 20, 1'b1, sweep_l[f], sweep_r[f]);
      half_frame(1'b1, 20, 1'b1, sweep_l[f], sweep_r[f]);
    end

    // Early LR edge after 8 data bits aborts the left word.
    cur_tag = "early_edge";
    half_frame(1'b0, 9, 1'b1, 16'hA5C3, 16'h3C5A);
    half_frame(1'b1, 20, 1'b1, 16'hA5C3, 16'h3C5A);

    // Sample changes mid-word must not reach the wire; en drop mid-word too.
    cur_tag = "midword_change";
    half_frame(1'b0, 6, 1'b1, 16'h5A0F, 16'h0000);
    half_frame(1'b0, 14, 1'b0, 16'hFFFF, 16'hFFFF);
    cur_tag = "en_off_edge";
    half_frame(1'b1, 20, 1'b0, 16'hFFFF, 16'hFFFF);

    // Asynchronous reset mid-word: output must drop before the next clock.
    cur_tag = "async_reset";
    half_frame(1'b0, 6, 1'b1, 16'hFFFF, 16'hFFFF);
    @(negedge i_bclk);
    i_rst_n = 1'b1;
    #1;
    model_edge();
    check_output();
    run_cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    run_cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    @(negedge i_bclk);
    i_rst_n = 1'b0;
    cur_tag = "after_reset";
    half_frame(1'b0, 4, 1'b1, 16'hFFFF, 16'hFFFF);
    half_frame(1'b1, 20, 1'b1, 16'h1234, 16'hB00B);

    // Random half-frames: lengths around the word size, random enable,
    // random samples, and random mid-word input changes.
    cur_tag = "random";
    for (int f = 0; f < 40; f++) begin
      logic        lr;
      logic        en;
      logic [15:0] l;
      logic [15:0] r;
      int          len;
      int          chg;
      lr  = (f % 2 == 0) ? 1'b0 : 1'b1;
      len = $urandom_range(8, 24);
      chg = $urandom_range(1, 23);
      en  = ($urandom_range(0, 3) != 0);
      l   = 16'($urandom);
      r   = 16'($urandom);
      for (int k = 0; k < len; k++) begin
        if (k == chg) begin
          l  = 16'($urandom);
          r  = 16'($urandom);
          en = ~en;
        end
        run_cycle(lr, en, l, r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog so a stalled run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule : tb_aud_player
